// File: rtl/jtframe_sdram64_sched.sv
// Command-bus scheduler for four 64-bit SDRAM bank controllers: rotating-priority
// grant, registered pin mux and periodic PRECHARGE-ALL + AUTO-REFRESH insertion.
module jtframe_sdram64_sched #(
    parameter int RFSH_PERIOD = 780,
    parameter int TRP         = 2,
    parameter int TRFC        = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_rfsh_en,
    input  logic [3:0]  i_br,
    input  logic [3:0]  i_bank_idle,
    input  logic [15:0] i_bank_cmd,
    input  logic [51:0] i_bank_a,
    output logic [3:0]  o_bg,
    output logic [3:0]  o_cmd,
    output logic [12:0] o_sdram_a,
    output logic [1:0]  o_ba,
    output logic [3:0]  o_set_prech,
    output logic        o_rfsh_busy
);

    localparam logic [3:0] CMD_NOP     = 4'b0111;
    localparam logic [3:0] CMD_PRECH   = 4'b0010;
    localparam logic [3:0] CMD_REFRESH = 4'b0001;

    localparam int CNT_W    = $clog2(RFSH_PERIOD);
    localparam int WAIT_MAX = (TRP > TRFC) ? TRP : TRFC;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        ST_NORMAL,
        ST_WAIT_IDLE,
        ST_PRECH,
        ST_TRP_W,
        ST_RFSH,
        ST_TRFC_W
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [WAIT_W-1:0]   r_wait;
    logic [WAIT_W-1:0]   w_wait_next;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_pending;
    logic [1:0]          r_ptr;
    logic [3:0]          r_cmd;
    logic [12:0]         r_a;
    logic [1:0]          r_ba;
    logic [3:0]          r_set_prech;
    logic                r_busy;

    logic [3:0]          w_allow;
    logic [3:0]          w_elig;
    logic                w_gnt_valid;
    logic [1:0]          w_gnt_idx;
    logic [1:0]          w_scan;
    logic [3:0]          w_cmds  [4];
    logic [12:0]         w_addrs [4];
    logic                w_gnt_used;
    logic                w_issue_prech;
    logic                w_issue_rfsh;
    logic                w_wrap;

    assign o_cmd       = r_cmd;
    assign o_sdram_a   = r_a;
    assign o_ba        = r_ba;
    assign o_set_prech = r_set_prech;
    assign o_rfsh_busy = r_busy;

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            w_cmds[b]  = i_bank_cmd[b*4 +: 4];
            w_addrs[b] = i_bank_a[b*13 +: 13];
        end
    end

    // While waiting for idle, only banks with a transaction in flight may finish it
    always_comb begin
        w_allow = 4'h0;
        case (r_state)
            ST_NORMAL:    w_allow = 4'hF;
            ST_WAIT_IDLE: w_allow = ~i_bank_idle;
            default:      w_allow = 4'h0;
        endcase
        w_elig = rst ? 4'h0 : (i_br & w_allow);
    end

    // Scan from the far end so the bank closest to the pointer overwrites the others
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_idx   = 2'd0;
        w_scan      = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            w_scan = r_ptr + k[1:0];
            if (w_elig[w_scan]) begin
                w_gnt_valid = 1'b1;
                w_gnt_idx   = w_scan;
            end
        end
        o_bg       = w_gnt_valid ? (4'b0001 << w_gnt_idx) : 4'h0;
        w_gnt_used = w_gnt_valid && (w_cmds[w_gnt_idx] != CMD_NOP);
    end

    always_comb begin
        w_next        = r_state;
        w_wait_next   = r_wait;
        w_issue_prech = 1'b0;
        w_issue_rfsh  = 1'b0;
        case (r_state)
            ST_NORMAL: begin
                if (r_pending) w_next = ST_WAIT_IDLE;
            end
            ST_WAIT_IDLE: begin
                if (i_bank_idle == 4'hF && !w_gnt_valid) w_next = ST_PRECH;
            end
            ST_PRECH: begin
                w_issue_prech = 1'b1;
                w_wait_next   = WAIT_W'(TRP - 1);
                w_next        = ST_TRP_W;
            end
            ST_TRP_W: begin
                if (r_wait == '0) w_next = ST_RFSH;
                else              w_wait_next = r_wait - WAIT_W'(1);
            end
            ST_RFSH: begin
                w_issue_rfsh = 1'b1;
                w_wait_next  = WAIT_W'(TRFC - 1);
                w_next       = ST_TRFC_W;
            end
            ST_TRFC_W: begin
                if (r_wait == '0) w_next = ST_NORMAL;
                else              w_wait_next = r_wait - WAIT_W'(1);
            end
            default: w_next = ST_NORMAL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_NORMAL;
            r_wait  <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_wait_next;
            r_busy  <= (w_next != ST_NORMAL);
        end
    end

    assign w_wrap = (r_cnt == CNT_W'(RFSH_PERIOD - 1));

    // A wrap that lands while a refresh is still owed is dropped, not queued
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_pending <= 1'b0;
        end else begin
            if (i_rfsh_en) begin
                if (w_wrap) r_cnt <= '0;
                else        r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_issue_rfsh)            r_pending <= 1'b0;
            else if (i_rfsh_en && w_wrap) r_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= 2'd0;
        end else if (w_gnt_used) begin
            r_ptr <= w_gnt_idx + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd       <= CMD_NOP;
            r_a         <= '0;
            r_ba        <= '0;
            r_set_prech <= 4'h0;
        end else begin
            r_set_prech <= 4'h0;
            if (w_issue_prech) begin
                r_cmd <= CMD_PRECH;
                r_a   <= 13'h0400;
                r_ba  <= 2'd0;
            end else if (w_issue_rfsh) begin
                r_cmd       <= CMD_REFRESH;
                r_set_prech <= 4'hF;
            end else if (w_gnt_valid) begin
                r_cmd <= w_cmds[w_gnt_idx];
                r_a   <= w_addrs[w_gnt_idx];
                r_ba  <= w_gnt_idx;
            end else begin
                r_cmd <= CMD_NOP;
            end
        end
    end

endmodule

// File: tb/tb_jtframe_sdram64_sched.sv
// Bench for jtframe_sdram64_sched: directed scenarios plus random traffic, all checked
// against a cycle-level reference model of grant rotation and refresh timing.
module tb_jtframe_sdram64_sched;

    localparam int RFSH_PERIOD = 780;
    localparam int TRP         = 2;
    localparam int TRFC        = 7;
    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] REF = 4'b0001;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rfshEn = 1'b0;
    logic [3:0]  br = 4'h0;
    logic [3:0]  bankIdle = 4'hF;
    logic [15:0] bankCmd = 16'h7777;
    logic [51:0] bankA = '0;
    logic [3:0]  bg;
    logic [3:0]  cmd;
    logic [12:0] sdramA;
    logic [1:0]  ba;
    logic [3:0]  setPrech;
    logic        rfshBusy;

    always #5 clk = ~clk;

    jtframe_sdram64_sched #(.RFSH_PERIOD(RFSH_PERIOD), .TRP(TRP), .TRFC(TRFC)) dut (
        .clk(clk), .rst(rst), .i_rfsh_en(rfshEn), .i_br(br), .i_bank_idle(bankIdle),
        .i_bank_cmd(bankCmd), .i_bank_a(bankA), .o_bg(bg), .o_cmd(cmd),
        .o_sdram_a(sdramA), .o_ba(ba), .o_set_prech(setPrech), .o_rfsh_busy(rfshBusy)
    );

    int errors = 0;
    int checks = 0;

    // Model: mMode 0 = bus open, 1 = refresh owed and draining, 2 = refresh sequence
    // where mPhase counts cycles since PRECHARGE-ALL was scheduled.
    int          mPtr, mCount, mMode, mPhase, edges;
    bit          mPending;
    logic [3:0]  eCmd, eSet, obsBg;
    logic [12:0] eA;
    logic [1:0]  eBa;
    logic        eBusy;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mPtr = 0; mCount = 0; mMode = 0; mPhase = 0; mPending = 0; edges = 0;
        eCmd = NOP; eA = '0; eBa = '0; eSet = 4'h0; eBusy = 1'b0;
    endtask

    function automatic int modelGrant();
        logic [3:0] allow;
        allow = (mMode == 0) ? 4'hF : (mMode == 1) ? ~bankIdle : 4'h0;
        for (int k = 0; k < 4; k++)
            if (br[(mPtr + k) % 4] && allow[(mPtr + k) % 4]) return (mPtr + k) % 4;
        return -1;
    endfunction

    task automatic modelEdge(input int g);
        bit wrapped;
        bit issuedRef;
        wrapped   = 0;
        issuedRef = (mMode == 2 && mPhase == TRP + 1);
        eSet = 4'h0;
        if (mMode == 2 && mPhase == 0) begin
            eCmd = PRE; eA = 13'h0400; eBa = 2'd0;
        end else if (issuedRef) begin
            eCmd = REF; eSet = 4'hF;
        end else if (g >= 0) begin
            eCmd = bankCmd[g*4 +: 4];
            eA   = bankA[g*13 +: 13];
            eBa  = 2'(g);
            if (eCmd != NOP) mPtr = (g + 1) % 4;
        end else begin
            eCmd = NOP;
        end
        if (rfshEn) begin
            if (mCount == RFSH_PERIOD - 1) begin mCount = 0; wrapped = 1; end
            else mCount++;
        end
        case (mMode)
            0: if (mPending) mMode = 1;
            1: if (bankIdle == 4'hF && g < 0) begin mMode = 2; mPhase = 0; end
            default: if (mPhase == TRP + TRFC + 1) mMode = 0; else mPhase++;
        endcase
        if (issuedRef)    mPending = 0;
        else if (wrapped) mPending = 1;
        eBusy = (mMode != 0);
    endtask

    // Called just after a falling edge with inputs already set
    task automatic stepCycle();
        int g;
        logic [3:0] eBg;
        #1;
        g   = modelGrant();
        eBg = (g < 0) ? 4'h0 : 4'(1 << g);
        obsBg = bg;
        checkOutput("bg", 16'(bg), 16'(eBg));
        @(posedge clk);
        modelEdge(g);
        edges++;
        @(negedge clk);
        checkOutput("cmd", 16'(cmd), 16'(eCmd));
        checkOutput("sdram_a", 16'(sdramA), 16'(eA));
        checkOutput("ba", 16'(ba), 16'(eBa));
        checkOutput("set_prech", 16'(setPrech), 16'(eSet));
        checkOutput("rfsh_busy", 16'(rfshBusy), 16'(eBusy));
    endtask

    task automatic applyStimulus(input logic [3:0] brV, input logic [3:0] idleV,
                                 input logic [15:0] cmdV, input logic [51:0] aV, input logic enV);
        br = brV; bankIdle = idleV; bankCmd = cmdV; bankA = aV; rfshEn = enV;
        stepCycle();
    endtask

    task automatic applyIdle();
        applyStimulus(4'h0, 4'hF, 16'h7777, 52'h0, 1'b1);
    endtask

    task automatic applyRandom(input logic enV);
        logic [15:0] c;
        logic [51:0] a;
        for (int b = 0; b < 4; b++) begin
            c[b*4 +: 4]   = ($urandom_range(0, 3) == 0) ? NOP : 4'($urandom);
            a[b*13 +: 13] = 13'($urandom);
        end
        applyStimulus(4'($urandom), 4'($urandom) | 4'($urandom), c, a, enV);
    endtask

    task automatic applyReset();
        rst = 1'b1;
        #1;
        checkOutput("rstCmd", 16'(cmd), 16'(NOP));
        checkOutput("rstBusy", 16'(rfshBusy), 16'h0);
        checkOutput("rstBg", 16'(bg), 16'h0);
        repeat (2) @(negedge clk);
        checkOutput("rstA", 16'(sdramA), 16'h0);
        checkOutput("rstBa", 16'(ba), 16'h0);
        checkOutput("rstSetPrech", 16'(setPrech), 16'h0);
        rst = 1'b0;
        modelReset();
    endtask

    initial begin
        logic [3:0] order [5];
        int n;
        int busyCnt;
        #1;
        br = 4'hF; rfshEn = 1'b1;
        applyReset();

        // Rotation from a fresh pointer: every grant used
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'hF, 4'h0, 16'h3333, 52'h0, 1'b1);
            order[i] = obsBg;
        end
        checkOutput("order0", 16'(order[0]), 16'h1);
        checkOutput("order1", 16'(order[1]), 16'h2);
        checkOutput("order2", 16'(order[2]), 16'h4);
        checkOutput("order3", 16'(order[3]), 16'h8);
        checkOutput("order4", 16'(order[4]), 16'h1);

        applyStimulus(4'b0100, 4'hF, 16'h7577, {13'h0, 13'h123, 26'h0}, 1'b1);
        checkOutput("readBg", 16'(obsBg), 16'h4);
        checkOutput("readCmd", 16'(cmd), 16'h5);
        checkOutput("readA", 16'(sdramA), 16'h123);
        checkOutput("readBa", 16'(ba), 16'h2);

        n = 0;
        while (cmd !== PRE && n < 2000) begin applyIdle(); n++; end
        checkOutput("prechEdge", 16'(edges), 16'(RFSH_PERIOD + 3));
        checkOutput("prechA10", 16'(sdramA), 16'h400);
        repeat (TRP + 1) applyIdle();
        checkOutput("refCmd", 16'(cmd), 16'(REF));
        checkOutput("refSetPrech", 16'(setPrech), 16'hF);
        for (int i = 0; i < TRFC; i++) begin
            applyStimulus(4'hF, 4'hF, 16'h3333, 52'h0, 1'b1);
            checkOutput("bgInTrfc", 16'(obsBg), 16'h0);
        end
        applyStimulus(4'hF, 4'hF, 16'h3333, 52'h0, 1'b1);
        checkOutput("bgAfterTrfc", 16'(obsBg == 4'h0), 16'h0);

        // Refresh owed while bank1 is mid-transaction and bank3 is idle
        n = 0;
        while (mMode != 1 && n < 2000) begin applyIdle(); n++; end
        checkOutput("waitTimeout", 16'(n >= 2000), 16'h0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b1010, 4'b1101, 16'h7757, 52'h0, 1'b1);
            checkOutput("inflightBg", 16'(obsBg), 16'h2);
            checkOutput("noPrechYet", 16'(cmd == PRE), 16'h0);
        end
        n = 0;
        while (mMode != 0 && n < 40) begin
            applyStimulus(4'b1000, 4'hF, 16'h3777, 52'h0, 1'b1);
            n++;
        end
        checkOutput("seqTimeout", 16'(n >= 40), 16'h0);
        applyStimulus(4'b1000, 4'hF, 16'h3777, 52'h0, 1'b1);
        checkOutput("bank3After", 16'(obsBg), 16'h8);

        // Reset in the middle of the precharge wait
        n = 0;
        while (!(mMode == 2 && mPhase == 1) && n < 2000) begin applyIdle(); n++; end
        checkOutput("trpTimeout", 16'(n >= 2000), 16'h0);
        applyReset();
        n = 0;
        while (cmd !== PRE && n < 2000) begin applyIdle(); n++; end
        checkOutput("prechAfterRst", 16'(edges), 16'(RFSH_PERIOD + 3));

        n = 0;
        while (mMode != 0 && n < 40) begin applyIdle(); n++; end
        busyCnt = 0;
        for (int i = 0; i < 2000; i++) begin
            applyRandom(1'b0);
            if (rfshBusy) busyCnt++;
        end
        checkOutput("busyDisabled", 16'(busyCnt), 16'h0);

        for (int i = 0; i < 3000; i++) applyRandom(1'($urandom_range(0, 9) != 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
